// File: rtl/chacha_keystream_gen.sv
// -----------------------------------------------------------------------------
// chacha_keystream_gen
//
// Iterative ChaCha keystream generator. One start produces a run of
// consecutive 512-bit keystream blocks, auto-incrementing the block counter
// between blocks. One half-round (four quarter-rounds in parallel) is computed
// per clock; blocks are presented on a valid/ready handshake.
//
// Parameters:
//   ROUND_COUNT   number of double rounds (10 = ChaCha20, 6 = ChaCha12,
//                 4 = ChaCha8), 1..15
//   COUNTER_WIDTH 32 (IETF, 96-bit nonce) or 64 (original, 64-bit nonce)
//
// Ports:
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset
//   key_i         256-bit key, [255:224] = state word 4 ... [31:0] = word 11
//   nonce_i       nonce, MSB word goes to the lowest state word after counter
//   counter_i     initial block counter
//   num_blocks_i  number of blocks in the run (0 = immediate done)
//   start_i       start request, accepted only while ready_o = 1
//   ready_o       idle, a start will be accepted
//   ks_valid_o    keystream_o / counter_o hold a block
//   ks_ready_i    consumer accepts the block
//   data_i        (CHACHA_XOR_EN only) data XORed onto keystream_o
//   keystream_o   block, state word 0 at [511:480], word 15 at [31:0]
//   counter_o     counter of the block currently on keystream_o
//   done_o        one-cycle pulse when the run completes
//   overflow_o    sticky, the counter wrapped during the run
//
// Build option:
//   CHACHA_XOR_EN  when defined, adds data_i and drives
//                  keystream_o = keystream ^ data_i (combinational on data_i).
// -----------------------------------------------------------------------------
module chacha_keystream_gen #(
    parameter int ROUND_COUNT   = 10,
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [255:0]               key_i,
    input  logic [127-COUNTER_WIDTH:0] nonce_i,
    input  logic [COUNTER_WIDTH-1:0]   counter_i,
    input  logic [15:0]                num_blocks_i,
    input  logic                       start_i,
    output logic                       ready_o,
    output logic                       ks_valid_o,
    input  logic                       ks_ready_i,
`ifdef CHACHA_XOR_EN
    input  logic [511:0]               data_i,
`endif
    output logic [511:0]               keystream_o,
    output logic [COUNTER_WIDTH-1:0]   counter_o,
    output logic                       done_o,
    output logic                       overflow_o
);

    localparam int             NONCE_W   = 128 - COUNTER_WIDTH;
    localparam logic [4:0]     LAST_HALF = 5'(2 * ROUND_COUNT);

    typedef logic [15:0][31:0] state_t;  // index = ChaCha state word number

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_OUTPUT
    } fsm_t;

    generate
        if (ROUND_COUNT < 1 || ROUND_COUNT > 15 ||
            (COUNTER_WIDTH != 32 && COUNTER_WIDTH != 64)) begin : g_bad_param
            $error("chacha_keystream_gen: illegal ROUND_COUNT or COUNTER_WIDTH");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Arithmetic helpers
    // ------------------------------------------------------------------
    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] quarter_round(input logic [31:0] a_in,
                                                   input logic [31:0] b_in,
                                                   input logic [31:0] c_in,
                                                   input logic [31:0] d_in);
        logic [31:0] a, b, c, d;
        a = a_in;
        b = b_in;
        c = c_in;
        d = d_in;
        a = a + b;  d = rotl(d ^ a, 16);
        c = c + d;  b = rotl(b ^ c, 12);
        a = a + b;  d = rotl(d ^ a, 8);
        c = c + d;  b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    // Column round when diag = 0, diagonal round when diag = 1. The four
    // quarter-rounds touch disjoint words, so all read from the input state.
    function automatic state_t half_round(input state_t s, input logic diag);
        state_t       r;
        logic [127:0] q;
        int           ib, ic, id;
        r = s;
        for (int i = 0; i < 4; i++) begin
            ib = diag ? 4  + ((i + 1) % 4) : 4  + i;
            ic = diag ? 8  + ((i + 2) % 4) : 8  + i;
            id = diag ? 12 + ((i + 3) % 4) : 12 + i;
            q  = quarter_round(s[i], s[ib], s[ic], s[id]);
            r[i]  = q[127:96];
            r[ib] = q[95:64];
            r[ic] = q[63:32];
            r[id] = q[31:0];
        end
        return r;
    endfunction

    // tail = {nonce, counter}; always 128 bits regardless of the split.
    function automatic state_t build_state(input logic [255:0] key,
                                           input logic [127:0] tail);
        state_t s;
        s[0] = 32'h61707865;
        s[1] = 32'h3320646e;
        s[2] = 32'h79622d32;
        s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) begin
            s[4 + i] = key[255 - 32 * i -: 32];
        end
        if (COUNTER_WIDTH == 64) begin
            s[12] = tail[31:0];
            s[13] = tail[63:32];
            s[14] = tail[127:96];
            s[15] = tail[95:64];
        end else begin
            s[12] = tail[31:0];
            s[13] = tail[127:96];
            s[14] = tail[95:64];
            s[15] = tail[63:32];
        end
        return s;
    endfunction

    // Word-wise feed-forward add, serialised with word 0 in the MSBs.
    function automatic logic [511:0] finalize(input state_t w, input state_t s);
        logic [511:0] out;
        for (int i = 0; i < 16; i++) begin
            out[511 - 32 * i -: 32] = w[i] + s[i];
        end
        return out;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    fsm_t                     state_q, state_d;
    logic [255:0]             key_q;
    logic [NONCE_W-1:0]       nonce_q;
    logic [COUNTER_WIDTH-1:0] ctr_q;
    logic [15:0]              remaining_q;
    logic [4:0]               round_cnt_q;
    state_t                   init_q;
    state_t                   work_q;
    logic [511:0]             ks_q;
    logic                     done_q;
    logic                     overflow_q;

    logic [COUNTER_WIDTH-1:0] ctr_inc;
    state_t                   start_state;
    state_t                   reload_state;
    state_t                   round_in;
    state_t                   round_out;
    logic                     round_diag;
    logic                     round_last;
    logic                     more_blocks;

    // ------------------------------------------------------------------
    // Datapath combinational logic
    // ------------------------------------------------------------------
    always_comb begin
        ctr_inc      = ctr_q + COUNTER_WIDTH'(1);
        start_state  = build_state(key_i, {nonce_i, counter_i});
        reload_state = build_state(key_q, {nonce_q, ctr_inc});
        round_last   = (round_cnt_q == LAST_HALF);
        more_blocks  = (remaining_q > 16'd1);
        // On a block handshake the first column round of the next block is
        // folded into the reload cycle, which keeps back-to-back blocks at one
        // per 2*ROUND_COUNT+1 cycles.
        if (state_q == S_OUTPUT) begin
            round_in   = reload_state;
            round_diag = 1'b0;
        end else begin
            round_in   = work_q;
            round_diag = round_cnt_q[0];
        end
        round_out = half_round(round_in, round_diag);
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ready_o    = 1'b0;
        ks_valid_o = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                ready_o = 1'b1;
                if (start_i && (num_blocks_i != 16'd0)) begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                if (round_last) begin
                    state_d = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                ks_valid_o = 1'b1;
                if (ks_ready_i) begin
                    state_d = more_blocks ? S_ROUND : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            key_q       <= '0;
            nonce_q     <= '0;
            ctr_q       <= '0;
            remaining_q <= '0;
            round_cnt_q <= '0;
            init_q      <= '0;
            work_q      <= '0;
            ks_q        <= '0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        key_q       <= key_i;
                        nonce_q     <= nonce_i;
                        ctr_q       <= counter_i;
                        remaining_q <= num_blocks_i;
                        round_cnt_q <= 5'd0;
                        init_q      <= start_state;
                        work_q      <= start_state;
                        overflow_q  <= 1'b0;
                        done_q      <= (num_blocks_i == 16'd0);
                    end
                end
                S_ROUND: begin
                    if (round_last) begin
                        ks_q <= finalize(work_q, init_q);
                    end else begin
                        work_q      <= round_out;
                        round_cnt_q <= round_cnt_q + 5'd1;
                    end
                end
                S_OUTPUT: begin
                    if (ks_ready_i) begin
                        if (more_blocks) begin
                            ctr_q       <= ctr_inc;
                            remaining_q <= remaining_q - 16'd1;
                            init_q      <= reload_state;
                            work_q      <= round_out;
                            round_cnt_q <= 5'd1;
                            if (&ctr_q) begin
                                overflow_q <= 1'b1;
                            end
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
`ifdef CHACHA_XOR_EN
    assign keystream_o = ks_q ^ data_i;
`else
    assign keystream_o = ks_q;
`endif
    assign counter_o  = ctr_q;
    assign done_o     = done_q;
    assign overflow_o = overflow_q;

endmodule
